// File: rtl/seq_pc_ctrl.sv
// Multi-cycle sequencer for the SEQ Y86-64 core: owns the PC, walks the six
// instruction stages with one-hot enables, and tracks status and counters.
module seq_pc_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          IMEM_BYTES  = 1024,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        hlt,
  input  logic        imem_error,
  input  logic        instr_valid,
  input  logic        cnd,
  input  logic [63:0] valM,
  input  logic        mem_ready,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic [5:0]  stage_en,
  output logic [2:0]  stat,
  output logic        running,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_STOP
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic [2:0]  stat_reg, stat_next;
  logic [31:0] wait_reg, wait_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] cycle_reg, cycle_next;

  logic        pc_bad;
  logic        mem_icode;
  logic        in_stage;
  logic [31:0] instr_inc;

  assign pc_bad    = (pc_reg >= 64'(IMEM_BYTES));
  assign mem_icode = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign in_stage  = (state_reg != S_IDLE) && (state_reg != S_STOP);
  assign instr_inc = (instr_reg == 32'hFFFF_FFFF) ? instr_reg : instr_reg + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      stat_reg  <= STAT_AOK;
      wait_reg  <= 32'd0;
      instr_reg <= 32'd0;
      cycle_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      stat_reg  <= stat_next;
      wait_reg  <= wait_next;
      instr_reg <= instr_next;
      cycle_reg <= cycle_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    stat_next  = stat_reg;
    wait_next  = wait_reg;
    instr_next = instr_reg;
    cycle_next = cycle_reg;

    if (in_stage && (cycle_reg != 32'hFFFF_FFFF))
      cycle_next = cycle_reg + 32'd1;

    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (pc_bad) begin
          state_next = S_STOP;
          stat_next  = STAT_ADR;
        end else begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (imem_error) begin
          state_next = S_STOP;
          stat_next  = STAT_ADR;
        end else if (!instr_valid) begin
          state_next = S_STOP;
          stat_next  = STAT_INS;
        end else if (hlt) begin
          state_next = S_STOP;
          stat_next  = STAT_HLT;
          instr_next = instr_inc;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_next = S_MEMORY;
        wait_next  = 32'd0;
      end
      S_MEMORY: begin
        // Only memory-touching instructions look at the handshake.
        if (!mem_icode) begin
          state_next = S_WRITEBACK;
        end else if (mem_ready) begin
          if (dmem_error) begin
            state_next = S_STOP;
            stat_next  = STAT_ADR;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (wait_reg >= 32'(MEM_TIMEOUT - 1)) begin
          state_next = S_STOP;
          stat_next  = STAT_ADR;
        end else begin
          wait_next = wait_reg + 32'd1;
        end
      end
      S_WRITEBACK: begin
        state_next = S_PCUPD;
      end
      S_PCUPD: begin
        if (icode == 4'h8 || (icode == 4'h7 && cnd))
          pc_next = valC;
        else if (icode == 4'h9)
          pc_next = valM;
        else
          pc_next = valP;
        instr_next = instr_inc;
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_STOP;
      end
    endcase
  end

  // Fetch enable is suppressed when the PC is already out of range.
  always_comb begin
    stage_en = 6'b000000;
    case (state_reg)
      S_FETCH:     stage_en[0] = !pc_bad;
      S_DECODE:    stage_en[1] = 1'b1;
      S_EXECUTE:   stage_en[2] = 1'b1;
      S_MEMORY:    stage_en[3] = 1'b1;
      S_WRITEBACK: stage_en[4] = 1'b1;
      S_PCUPD:     stage_en[5] = 1'b1;
      default:     stage_en    = 6'b000000;
    endcase
  end

  assign running     = in_stage;
  assign PC          = pc_reg;
  assign stat        = stat_reg;
  assign instr_count = instr_reg;
  assign cycle_count = cycle_reg;

endmodule
